// File: rtl/crc_seq_pkg.sv
// rtl/crc_seq_pkg.sv - shared types and constants for the CRC sequencing controller
//
// Purpose: operation and FSM state encodings, default CRC constants and the
// byte-count width used by crc_seq_ctrl.
// Ports: none (package).

package crc_seq_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_BYTE  = 2'd1,
    OP_WORD  = 2'd2,
    OP_READ  = 2'd3
  } crc_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } crc_seq_state_t;

  localparam logic [31:0] CRC_INIT_DEFAULT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOR_OUT_DEFAULT = 32'hFFFF_FFFF;

  // Remaining-byte counter; a 32-bit word holds at most 4 bytes.
  localparam int CRC_CNT_W = 2;
  typedef logic [CRC_CNT_W-1:0] crc_cnt_t;

endpackage

// File: rtl/crc_seq_ctrl.sv
// rtl/crc_seq_ctrl.sv - sequencing controller for the byte-wise table-lookup CRC datapath
//
// Purpose: accepts CFU CRC operations on a valid/ready request port, holds the
// running CRC, feeds the external single-byte lookup step one byte per cycle
// and returns results on a valid/ready response port.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_op                0=OP_RESET 1=OP_BYTE 2=OP_WORD 3=OP_READ
//   req_data0             byte in [7:0] (OP_BYTE) or 32-bit word (OP_WORD)
//   req_data1             [1:0] = byte count minus 1 for OP_WORD (partial build only)
//   resp_valid/resp_ready response handshake
//   resp_data             result (OP_READ returns crc ^ XOR_OUT, others raw crc)
//   dp_data0              datapath byte operand {24'b0, current byte}
//   dp_data1              datapath state operand (crc_reg)
//   dp_result             datapath combinational step result
//
// Build option: CRC_SEQ_PARTIAL_EN - when defined, OP_WORD processes
// req_data1[1:0]+1 low-order bytes instead of always 4.

module crc_seq_ctrl
  import crc_seq_pkg::*;
#(
  parameter logic [31:0] INIT_VALUE = CRC_INIT_DEFAULT,
  parameter logic [31:0] XOR_OUT    = CRC_XOR_OUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] dp_data0,
  output logic [31:0] dp_data1,
  input  logic [31:0] dp_result
);

  crc_seq_state_t state, state_d;
  logic [31:0]    crc_reg, crc_d;
  logic [31:0]    shreg, shreg_d;
  crc_cnt_t       cnt, cnt_d;
  logic [31:0]    resp_q, resp_d;
  crc_cnt_t       word_cnt;
  crc_op_t        op;
  logic           unused_req_bits;

  assign op = crc_op_t'(req_op);

`ifdef CRC_SEQ_PARTIAL_EN
  assign word_cnt        = req_data1[CRC_CNT_W-1:0];
  assign unused_req_bits = ^req_data1[31:CRC_CNT_W];
`else
  assign word_cnt        = '1;
  assign unused_req_bits = ^req_data1;
`endif

  // Datapath operands come only from registers, so there is no
  // combinational path from the request port into the lookup step.
  assign dp_data0   = {24'b0, shreg[7:0]};
  assign dp_data1   = crc_reg;

  assign resp_valid = (state == RESP);
  assign resp_data  = resp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      crc_reg <= INIT_VALUE;
      shreg   <= '0;
      cnt     <= '0;
      resp_q  <= '0;
    end else begin
      state   <= state_d;
      crc_reg <= crc_d;
      shreg   <= shreg_d;
      cnt     <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d   = state;
    crc_d     = crc_reg;
    shreg_d   = shreg;
    cnt_d     = cnt;
    resp_d    = resp_q;
    // Gate with rst so nothing looks acceptable while reset is held.
    req_ready = (state == IDLE) && !rst;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          case (op)
            OP_RESET: begin
              crc_d   = INIT_VALUE;
              resp_d  = INIT_VALUE;
              state_d = RESP;
            end
            OP_READ: begin
              resp_d  = crc_reg ^ XOR_OUT;
              state_d = RESP;
            end
            OP_BYTE: begin
              shreg_d = req_data0;
              cnt_d   = '0;
              state_d = BUSY;
            end
            OP_WORD: begin
              shreg_d = req_data0;
              cnt_d   = word_cnt;
              state_d = BUSY;
            end
            default: state_d = IDLE;
          endcase
        end
      end

      BUSY: begin
        // One byte per cycle, least significant byte first.
        crc_d   = dp_result;
        shreg_d = shreg >> 8;
        if (cnt == '0) begin
          resp_d  = dp_result;
          state_d = RESP;
        end else begin
          cnt_d = cnt - crc_cnt_t'(1);
        end
      end

      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// tb/tb_crc_seq_ctrl.sv - self-checking bench for crc_seq_ctrl with a CRC-32 reference model

module tb_crc_seq_ctrl;

  localparam logic [31:0] INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] XOUT = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY = 32'hEDB8_8320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_data0 = '0;
  logic [31:0] req_data1 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [31:0] dp_data0;
  logic [31:0] dp_data1;
  logic [31:0] dp_result;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_crc = INIT;

  always #5 clk = ~clk;

  crc_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .dp_data0   (dp_data0),
    .dp_data1   (dp_data1),
    .dp_result  (dp_result)
  );

  // Reflected CRC-32 of a single byte, bit-serial.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'b0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    return c;
  endfunction

  // Sibling lookup datapath: table entry for the index, then shift-in of the old state.
  always_comb dp_result = crc_byte(32'h0, dp_data0[7:0] ^ dp_data1[7:0]) ^ (dp_data1 >> 8);

  // Reference model: applies one operation to the running CRC, returns the
  // expected response and accept-to-valid latency.
  task automatic model_op(input logic [1:0] op, input logic [31:0] d0, input logic [31:0] d1,
                          output logic [31:0] exp_data, output int exp_lat);
    int nbytes;
    case (op)
      2'd0: begin model_crc = INIT; exp_data = INIT; exp_lat = 1; end
      2'd3: begin exp_data = model_crc ^ XOUT; exp_lat = 1; end
      2'd1: begin model_crc = crc_byte(model_crc, d0[7:0]); exp_data = model_crc; exp_lat = 2; end
      default: begin
`ifdef CRC_SEQ_PARTIAL_EN
        nbytes = int'(d1[1:0]) + 1;
`else
        nbytes = 4;
`endif
        for (int i = 0; i < nbytes; i++) model_crc = crc_byte(model_crc, d0[8*i +: 8]);
        exp_data = model_crc;
        exp_lat  = nbytes + 1;
      end
    endcase
  endtask

  // Issue one request, measure latency, capture the response, then consume it.
  task automatic run_op(input logic [1:0] op, input logic [31:0] d0, input logic [31:0] d1,
                        input int stall, output logic [31:0] data, output int lat, output bit ok);
    int guard;
    ok = 1'b0; data = '0; lat = 0;
    @(negedge clk);
    req_op = op; req_data0 = d0; req_data1 = d1; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (req_ready) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      data = resp_data;
      ok = resp_valid;
      repeat (stall) @(negedge clk);
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
    checks++; if (dp_data1 !== INIT) begin errors++; $display("FAIL reset_dp_data1 got %h want %h", dp_data1, INIT); end
    checks++; if (dp_data0 !== 32'h0) begin errors++; $display("FAIL reset_dp_data0 got %h want 0", dp_data0); end
    @(negedge clk); rst = 1'b0;
    model_crc = INIT;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_read_after_reset;
    logic [31:0] d; int lat; bit ok;
    run_op(2'd3, 32'h0, 32'h0, 0, d, lat, ok);
    checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL read_after_reset got %h ok=%0d want 00000000", d, ok); end
    checks++; if (lat != 1) begin errors++; $display("FAIL read_latency got %0d want 1", lat); end
  endtask

  task automatic test_single_byte;
    logic [31:0] d; int lat; bit ok;
    run_op(2'd0, 32'h0, 32'h0, 0, d, lat, ok);
    checks++; if (!ok || d !== INIT || lat != 1) begin errors++; $display("FAIL reset_op got %h lat %0d want %h lat 1", d, lat, INIT); end
    run_op(2'd1, 32'h61, 32'h0, 1, d, lat, ok);
    checks++; if (!ok || lat != 2) begin errors++; $display("FAIL byte_latency got %0d want 2", lat); end
    run_op(2'd3, 32'h0, 32'h0, 0, d, lat, ok);
    checks++; if (!ok || d !== 32'hE8B7BE43) begin errors++; $display("FAIL crc_a got %h want e8b7be43", d); end
    model_crc = crc_byte(INIT, 8'h61);
  endtask

  task automatic test_check_string;
    logic [31:0] d; int lat; bit ok;
    run_op(2'd0, 32'h0, 32'h0, 0, d, lat, ok);
    run_op(2'd2, 32'h34333231, 32'h3, 0, d, lat, ok);
    checks++; if (!ok || lat != 5) begin errors++; $display("FAIL word1_latency got %0d want 5", lat); end
    run_op(2'd2, 32'h38373635, 32'h3, 2, d, lat, ok);
    checks++; if (!ok || lat != 5) begin errors++; $display("FAIL word2_latency got %0d want 5", lat); end
    run_op(2'd1, 32'h39, 32'h0, 0, d, lat, ok);
    checks++; if (!ok || d !== 32'h340BC6D9) begin errors++; $display("FAIL check_raw got %h want 340bc6d9", d); end
    run_op(2'd3, 32'h0, 32'h0, 0, d, lat, ok);
    checks++; if (!ok || d !== 32'hCBF43926) begin errors++; $display("FAIL check_value got %h want cbf43926", d); end
    model_crc = d ^ XOUT;
  endtask

  task automatic test_backpressure;
    logic [31:0] w, exp_word, exp_read, cap; int exp_lat, guard; bit bad_stable, bad_ready;
    w = $urandom;
    model_op(2'd2, w, 32'h3, exp_word, exp_lat);
    exp_read = model_crc ^ XOUT;
    @(negedge clk);
    req_op = 2'd2; req_data0 = w; req_data1 = 32'h3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = 2'd3;
    guard = 0;
    while (!resp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    cap = resp_data;
    checks++; if (!resp_valid || cap !== exp_word) begin errors++; $display("FAIL bp_word got %h want %h", cap, exp_word); end
    bad_stable = 1'b0; bad_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_data !== cap) bad_stable = 1'b1;
      if (req_ready !== 1'b0) bad_ready = 1'b1;
    end
    checks++; if (bad_stable) begin errors++; $display("FAIL bp_stable got %h want %h", resp_data, cap); end
    checks++; if (bad_ready) begin errors++; $display("FAIL bp_req_ready got 1 want 0 during stall"); end
    @(negedge clk); resp_ready = 1'b1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_bubble got %b want 0", req_ready); end
    @(posedge clk); #1; resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release valid %b ready %b want 0 1", resp_valid, req_ready); end
    @(posedge clk); #1; req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_data !== exp_read) begin errors++; $display("FAIL bp_read got %h want %h", resp_data, exp_read); end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] d; int lat; bit ok, rose;
    @(negedge clk);
    req_op = 2'd2; req_data0 = $urandom; req_data1 = 32'h3; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0 || dp_data1 !== INIT || req_ready !== 1'b0) begin
      errors++; $display("FAIL midreset valid %b crc %h ready %b want 0 %h 0", resp_valid, dp_data1, req_ready, INIT);
    end
    @(negedge clk); rst = 1'b0;
    model_crc = INIT;
    rose = 1'b0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (resp_valid) rose = 1'b1; end
    checks++; if (rose) begin errors++; $display("FAIL midreset_resp got 1 want 0"); end
    run_op(2'd3, 32'h0, 32'h0, 0, d, lat, ok);
    checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL midreset_read got %h want 00000000", d); end
  endtask

  task automatic test_random;
    logic [31:0] d, d0, d1, exp_d; logic [1:0] op; int lat, exp_lat, bad; bit ok;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      d0 = $urandom; d1 = $urandom;
      model_op(op, d0, d1, exp_d, exp_lat);
      run_op(op, d0, d1, int'($urandom_range(0, 3)), d, lat, ok);
      checks++;
      if (!ok || d !== exp_d || lat != exp_lat) begin
        errors++;
        $display("FAIL random_%0d op %0d got %h lat %0d want %h lat %0d", i, op, d, lat, exp_d, exp_lat);
      end
    end
  endtask

`ifdef CRC_SEQ_PARTIAL_EN
  task automatic test_partial;
    logic [31:0] d; int lat; bit ok;
    run_op(2'd0, 32'h0, 32'h0, 0, d, lat, ok);
    run_op(2'd2, 32'hA5C33231, 32'h1, 0, d, lat, ok);
    checks++; if (!ok || lat != 3) begin errors++; $display("FAIL partial_latency got %0d want 3", lat); end
    run_op(2'd3, 32'h0, 32'h0, 0, d, lat, ok);
    checks++; if (!ok || d !== 32'h4F5344CD) begin errors++; $display("FAIL partial_crc got %h want 4f5344cd", d); end
    model_crc = d ^ XOUT;
  endtask
`endif

  initial begin
    test_reset();
    test_read_after_reset();
    test_single_byte();
    test_check_string();
    test_backpressure();
    test_reset_mid_op();
`ifdef CRC_SEQ_PARTIAL_EN
    test_partial();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
